// File: rtl/imm_extend_unit.sv
// imm_extend_unit: registered immediate extension (sign, zero, upper-place)
// with multi-beat chain assembly of wide constants, valid/ready on both sides.
module imm_extend_unit #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [IN_W-1:0]  in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out,
    output logic             abort
);

    localparam int unsigned NCH   = OUT_W / IN_W;
    localparam int unsigned CNT_W = $clog2(NCH) + 1;
    localparam int unsigned EXT_W = OUT_W - IN_W;

    typedef enum logic [1:0] {
        MODE_SEXT  = 2'b00,
        MODE_ZEXT  = 2'b01,
        MODE_UPPER = 2'b10,
        MODE_CHAIN = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   acc_q, acc_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic               abort_q, abort_d;

    logic               accept;
    logic [OUT_W-1:0]   chain_next;
    logic [OUT_W-1:0]   ext_val;

    // Upstream may load whenever the output slot is empty or being drained.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign abort     = abort_q;

    // Shift the partial up one chunk and append the new one at the bottom.
    assign chain_next = (acc_q << IN_W) | OUT_W'(in);

    // Single-beat extension result for the non-chain modes.
    always_comb begin
        ext_val = '0;
        unique case (mode_e'(mode))
            MODE_SEXT:  ext_val = {{EXT_W{in[IN_W-1]}}, in};
            MODE_ZEXT:  ext_val = {{EXT_W{1'b0}}, in};
            MODE_UPPER: ext_val = {in, {EXT_W{1'b0}}};
            default:    ext_val = '0;
        endcase
    end

    // Next-state: chain accumulation, abort of partials, output slot loading.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_d       = out_q;
        out_valid_d = out_valid_q && !out_ready;
        abort_d     = 1'b0;

        if (accept) begin
            if (mode_e'(mode) == MODE_CHAIN) begin
                if (cnt_q == CNT_W'(NCH - 1)) begin
                    out_d       = chain_next;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    cnt_d       = '0;
                    state_d     = ST_IDLE;
                end else begin
                    acc_d   = chain_next;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_ACC;
                end
            end else begin
                if (state_q == ST_ACC) begin
                    abort_d = 1'b1;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
                state_d     = ST_IDLE;
                out_d       = ext_val;
                out_valid_d = 1'b1;
            end
        end
    end

    // State and datapath registers; synchronous reset drops any partial silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            abort_q     <= abort_d;
        end
    end

endmodule

// File: tb/tb_imm_extend_unit.sv
// Self-checking bench for imm_extend_unit: directed scenarios then random traffic
// against a transaction-level reference model.
module tb_imm_extend_unit;

    localparam int unsigned IN_W  = 8;
    localparam int unsigned OUT_W = 16;
    localparam int unsigned NCH   = OUT_W / IN_W;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       mode;
    logic [IN_W-1:0]  din;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] dout;
    logic             abort;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit               m_valid;
    logic [OUT_W-1:0] m_out;
    bit               m_abort;
    int unsigned      chain[$];
    int               abort_seen;

    imm_extend_unit #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .in        (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (dout),
        .abort     (abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected extension computed arithmetically from the immediate's value.
    function automatic logic [OUT_W-1:0] ref_ext(input int unsigned m, input int unsigned v);
        longint r;
        if (m == 0) r = (v >= 2**(IN_W-1)) ? longint'(v) - longint'(2**IN_W) : longint'(v);
        else if (m == 1) r = v;
        else r = longint'(v) * longint'(2**(OUT_W-IN_W));
        return OUT_W'(r);
    endfunction

    // One clock: drive inputs, check in_ready, advance model and DUT, check outputs.
    task automatic step(input logic v, input logic [1:0] m, input logic [IN_W-1:0] d,
                        input logic ordy, input logic rst);
        bit     acc;
        longint cv;
        in_valid  = v;
        mode      = m;
        din       = d;
        out_ready = ordy;
        reset     = rst;
        #1;
        check("in_ready", 32'(in_ready), 32'(!m_valid || ordy));
        acc     = v && (!m_valid || ordy);
        m_abort = 1'b0;
        if (rst) begin
            m_valid = 1'b0;
            m_out   = '0;
            chain.delete();
        end else begin
            if (ordy) m_valid = 1'b0;
            if (acc) begin
                if (m == 2'b11) begin
                    chain.push_back(int'(d));
                    if (chain.size() == NCH) begin
                        cv = 0;
                        foreach (chain[i]) cv = cv * longint'(2**IN_W) + longint'(chain[i]);
                        m_out   = OUT_W'(cv);
                        m_valid = 1'b1;
                        chain.delete();
                    end
                end else begin
                    if (chain.size() != 0) m_abort = 1'b1;
                    chain.delete();
                    m_out   = ref_ext(int'(m), int'(d));
                    m_valid = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        if (abort) abort_seen++;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out", 32'(dout), 32'(m_out));
        check("abort", 32'(abort), 32'(m_abort));
    endtask

    initial begin
        m_valid = 1'b0; m_out = '0; m_abort = 1'b0; abort_seen = 0;
        in_valid = 0; mode = 0; din = 0; out_ready = 1; reset = 1;

        // Reset and reset-state checks
        step(0, 2'b00, 8'h00, 1, 1);
        step(0, 2'b00, 8'h00, 1, 1);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out", 32'(dout), 32'd0);

        // Basic modes
        step(1, 2'b00, 8'hFF, 1, 0);
        check("sext_ff", 32'(dout), 32'h0000FFFF);
        step(1, 2'b00, 8'h7F, 1, 0);
        check("sext_7f", 32'(dout), 32'h0000007F);
        step(1, 2'b00, 8'h00, 1, 0);
        check("sext_00", 32'(dout), 32'h00000000);
        step(1, 2'b01, 8'h80, 1, 0);
        check("zext_80", 32'(dout), 32'h00000080);
        step(1, 2'b10, 8'h12, 1, 0);
        check("upper_12", 32'(dout), 32'h00001200);
        step(0, 2'b00, 8'h00, 1, 0);

        // Chains
        step(1, 2'b11, 8'hAB, 1, 0);
        check("chain_mid_valid", 32'(out_valid), 32'd0);
        step(1, 2'b11, 8'hCD, 1, 0);
        check("chain_abcd", 32'(dout), 32'h0000ABCD);
        step(1, 2'b11, 8'h01, 1, 0);
        step(1, 2'b11, 8'h02, 1, 0);
        check("chain_0102", 32'(dout), 32'h00000102);

        // Backpressure
        step(1, 2'b00, 8'h80, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 2'b01, 8'h05, 0, 0);
            check("bp_hold", 32'(dout), 32'h0000FF80);
        end
        step(1, 2'b01, 8'h05, 1, 0);
        check("bp_release", 32'(dout), 32'h00000005);
        check("bp_valid", 32'(out_valid), 32'd1);

        // Chain abort
        step(1, 2'b11, 8'hAB, 1, 0);
        step(1, 2'b01, 8'h33, 1, 0);
        check("abort_pulse", 32'(abort), 32'd1);
        check("abort_out", 32'(dout), 32'h00000033);
        step(1, 2'b11, 8'h11, 1, 0);
        check("abort_clear", 32'(abort), 32'd0);
        step(1, 2'b11, 8'h22, 1, 0);
        check("chain_1122", 32'(dout), 32'h00001122);

        // Reset mid-chain
        abort_seen = 0;
        step(1, 2'b11, 8'hAB, 1, 0);
        step(0, 2'b00, 8'h00, 1, 1);
        check("rstmid_valid", 32'(out_valid), 32'd0);
        check("rstmid_out", 32'(dout), 32'd0);
        step(1, 2'b11, 8'hCD, 1, 0);
        step(1, 2'b11, 8'hEF, 1, 0);
        check("chain_cdef", 32'(dout), 32'h0000CDEF);
        check("no_abort", 32'(abort_seen), 32'd0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [1:0] rm;
            rm = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            step(1'($urandom_range(0, 3) != 0), rm, IN_W'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 99) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
